// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage core: operand forwarding, load-use and PC-write
// interlocks, and a wait/timeout FSM for multi-cycle data-memory accesses.
module hazard_sched #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Match_1E_M,
    input  logic       Match_1E_W,
    input  logic       Match_2E_M,
    input  logic       Match_2E_W,
    input  logic       Match_12D_E,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCWrD,
    input  logic       BranchMissed,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemError
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mem_state_t;

    mem_state_t      state;
    logic [CW-1:0]   cnt;
    logic            pcw_e;
    logic            pcw_m;
    logic            pcw_w;
    logic            ldr_stall;
    logic            pc_pend;
    logic            mem_stall;

    // Forwarding: the younger result in M wins over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (Match_1E_M && RegWriteM)      ForwardAE = 2'b10;
        else if (Match_1E_W && RegWriteW) ForwardAE = 2'b01;
        if (Match_2E_M && RegWriteM)      ForwardBE = 2'b10;
        else if (Match_2E_W && RegWriteW) ForwardBE = 2'b01;
    end

    assign ldr_stall = Match_12D_E & MemtoRegE;
    assign pc_pend   = PCWrD | pcw_e | pcw_m;

    // ERR never stalls so the faulting instruction can drain out of M.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            ST_IDLE: mem_stall = MemReqM & ~MemReadyM;
            ST_WAIT: mem_stall = ~MemReadyM;
            default: mem_stall = 1'b0;
        endcase
    end

    // A memory stall freezes F..M and suppresses flushes; branch resolution repeats.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall | pc_pend;
            StallD = ldr_stall;
            FlushD = pc_pend | pcw_w | BranchMissed;
            FlushE = ldr_stall | BranchMissed;
        end
    end

    // PC-write shadow pipeline, held alongside the datapath during memory stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcw_e <= 1'b0;
            pcw_m <= 1'b0;
            pcw_w <= 1'b0;
        end else if (!mem_stall) begin
            pcw_e <= PCWrD & ~FlushE;
            pcw_m <= pcw_e;
            pcw_w <= pcw_m;
        end
    end

    // Memory wait FSM with timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            MemError <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MemReqM && !MemReadyM) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (MemReadyM) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(MEM_TIMEOUT)) begin
                        state    <= ST_ERR;
                        MemError <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: per-cycle expected outputs are queued as
// stimulus is driven, then popped and compared at the falling edge.
module tb_hazard_sched;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CW          = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic       RegWriteM, RegWriteW, MemtoRegE, PCWrD, BranchMissed;
    logic       MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW, MemError;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [11:0] sb[$];
    logic [11:0] exp_v;
    logic [11:0] obs_v;

    hazard_sched #(.MEM_TIMEOUT(MEM_TIMEOUT), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCWrD(PCWrD), .BranchMissed(BranchMissed),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemError(MemError)
    );

    always #5 clk = ~clk;

    // Output vector layout: {FA, FB, SF, SD, SE, SM, FD, FE, FW, ME}
    function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic me);
        return {fa, fb, sf, sd, se, sm, fd, fe, fw, me};
    endfunction

    function automatic logic [11:0] stall_vec(input logic me);
        return mk(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, me);
    endfunction

    function automatic logic [11:0] observe();
        return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, MemError};
    endfunction

    task automatic clear_inputs();
        Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0;
        Match_12D_E = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCWrD = 0; BranchMissed = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    // Queue the expectation for the inputs just driven, then move to the sample point.
    task automatic expect_cycle(input logic [11:0] e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        expect_cycle(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", obs_v, exp_v);
        end
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_forward();
        for (int step = 0; step < 6; step++) begin
            clear_inputs();
            if (step < 3) begin
                Match_1E_M = 1; Match_1E_W = 1;
            end else begin
                Match_2E_M = 1; Match_2E_W = 1;
            end
            RegWriteM = (step % 3 == 0);
            RegWriteW = (step % 3 != 2);
            case (step % 3)
                0:       exp_v = 12'b10_00_0000_000_0;
                1:       exp_v = 12'b01_00_0000_000_0;
                default: exp_v = 12'b00_00_0000_000_0;
            endcase
            if (step >= 3) exp_v = {2'b00, exp_v[11:10], exp_v[7:0]};
            expect_cycle(exp_v);
            exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL forward step %0d: got %b want %b", step, obs_v, exp_v);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        Match_12D_E = 1; MemtoRegE = 1;
        expect_cycle(mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0));
        exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL load_use stall: got %b want %b", obs_v, exp_v);
        end
        next_cycle();
        clear_inputs();
        expect_cycle(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL load_use release: got %b want %b", obs_v, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_pc_write();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            PCWrD = (c == 0);
            expect_cycle(mk(2'b00, 2'b00, logic'(c < 3), 0, 0, 0, logic'(c < 4), 0, 0, 0));
            exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL pc_write cycle %0d: got %b want %b", c, obs_v, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            MemReqM      = (c < 4);
            MemReadyM    = (c == 3);
            BranchMissed = (c < 4);
            if (c < 3)       exp_v = stall_vec(1'b0);
            else if (c == 3) exp_v = mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
            else             exp_v = '0;
            expect_cycle(exp_v);
            exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL mem_wait cycle %0d: got %b want %b", c, obs_v, exp_v);
            end
            next_cycle();
        end
    endtask

    // Timeout, the ERR cycle, a fresh request straight after ERR, and sticky MemError.
    task automatic test_timeout();
        for (int c = 0; c < 9; c++) begin
            clear_inputs();
            MemReqM   = (c <= 7);
            MemReadyM = (c == 7);
            if (c <= 4)      exp_v = stall_vec(1'b0);
            else if (c == 5) exp_v = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
            else if (c == 6) exp_v = stall_vec(1'b1);
            else             exp_v = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
            expect_cycle(exp_v);
            exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %b want %b", c, obs_v, exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_wait();
        int unsigned stalls;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            PCWrD   = (c == 0);
            MemReqM = (c == 1 || c == 2);
            reset   = (c == 3);
            #1;
            if (c == 0)      exp_v = mk(2'b00, 2'b00, 1, 0, 0, 0, 1, 0, 0, 1);
            else if (c < 3)  exp_v = stall_vec(1'b1);
            else             exp_v = '0;
            expect_cycle(exp_v);
            exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_wait cycle %0d: got %b want %b", c, obs_v, exp_v);
            end
            next_cycle();
        end
        reset = 1'b0;
        clear_inputs();
        MemReqM = 1;
        stalls  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!StallM) break;
            stalls++;
            next_cycle();
        end
        sb.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        exp_v = sb.pop_front(); obs_v = observe(); n_tests++;
        if (stalls != MEM_TIMEOUT + 1 || obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL restart_count: got %0d stalls out %b want %0d stalls out %b",
                     stalls, obs_v, MEM_TIMEOUT + 1, exp_v);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_forward();
        test_load_use();
        test_pc_write();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
